tick_prescaler: RTL and testbench

- Upstream timebase for the display/RTC sequencer FSM.
- Divides clk into two single-cycle pulses:
  - ovf: scan tick.
  - ovf_RTC: RTC tick, every RTC_DIV-th scan tick, coincident with ovf.
- A small control FSM gates counting.
- The downstream out_rst pulse can be fed to sync_clr to re-phase the RTC divider.

---
 rtl/tick_prescaler.sv | 145 ++++++++++++++
 tb/tb_tick_prescaler.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_prescaler.sv
`default_nettype none
// =============================================================================
// Module   : tick_prescaler
// Brief    : Scan tick (ovf) and RTC tick (ovf_RTC) divider gated by an
//            IDLE/ARM/RUN control FSM. Macro RUNTIME_DIV_EN adds loadable divisors.
// Revision : 1.0
// =============================================================================
module tick_prescaler #(
    parameter int SCAN_DIV = 1000,
    parameter int RTC_DIV  = 1000,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             fast,
    input  logic             sync_clr,
`ifdef RUNTIME_DIV_EN
    input  logic [CNT_W-1:0] div_scan,
    input  logic [CNT_W-1:0] div_rtc,
    input  logic             div_load,
`endif
    output logic             ovf,
    output logic             ovf_RTC,
    output logic [CNT_W-1:0] rtc_phase,
    output logic             running
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    localparam longint           c_cnt_max   = (longint'(1) << CNT_W) - 1;
    localparam bit               c_params_ok = (SCAN_DIV >= 1) && (longint'(SCAN_DIV) <= c_cnt_max) &&
                                               (RTC_DIV >= 1)  && (longint'(RTC_DIV) <= c_cnt_max);
    localparam logic [CNT_W-1:0] c_scan_div  = CNT_W'(SCAN_DIV);
    localparam logic [CNT_W-1:0] c_rtc_div   = CNT_W'(RTC_DIV);
    localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_scan_cnt;
    logic [CNT_W-1:0] r_rtc_cnt;
    logic             r_ovf;
    logic             r_ovf_rtc;
    logic             r_running;

    logic [CNT_W-1:0] w_scan_last;
    logic [CNT_W-1:0] w_rtc_div;
    logic [CNT_W-1:0] w_rtc_last;
    logic             w_load;
    logic             w_count;
    logic             w_scan_tc;
    logic             w_rtc_wrap;

`ifdef RUNTIME_DIV_EN
    logic [CNT_W-1:0] r_div_scan;
    logic [CNT_W-1:0] r_div_rtc;

    // Shadows never hold 0, so the "minus one" terminal values cannot wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div_scan <= c_scan_div;
            r_div_rtc  <= c_rtc_div;
        end else if (div_load) begin
            r_div_scan <= (div_scan == '0) ? c_one : div_scan;
            r_div_rtc  <= (div_rtc == '0) ? c_one : div_rtc;
        end
    end

    assign w_load      = div_load;
    assign w_scan_last = r_div_scan - c_one;
    assign w_rtc_div   = r_div_rtc;
`else
    assign w_load      = 1'b0;
    assign w_scan_last = c_scan_div - c_one;
    assign w_rtc_div   = c_rtc_div;
`endif

    assign w_rtc_last = fast ? '0 : (w_rtc_div - c_one);
    assign w_count    = (r_state == S_RUN) && en && !w_load;
    assign w_scan_tc  = (r_scan_cnt == w_scan_last);
    assign w_rtc_wrap = (r_rtc_cnt >= w_rtc_last);

    always_comb begin
        w_state_nxt = S_IDLE;
        case (r_state)
            S_IDLE:  w_state_nxt = en ? S_ARM : S_IDLE;
            S_ARM:   w_state_nxt = en ? S_RUN : S_IDLE;
            S_RUN:   w_state_nxt = en ? S_RUN : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_running  <= 1'b0;
            r_scan_cnt <= '0;
            r_rtc_cnt  <= '0;
            r_ovf      <= 1'b0;
            r_ovf_rtc  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_running <= (w_state_nxt == S_RUN);
            if (!w_count) begin
                // Leaving RUN, arming, idling or reloading divisors: restart from zero.
                r_scan_cnt <= '0;
                r_rtc_cnt  <= '0;
                r_ovf      <= 1'b0;
                r_ovf_rtc  <= 1'b0;
            end else begin
                r_ovf_rtc <= 1'b0;
                if (w_scan_tc) begin
                    r_scan_cnt <= '0;
                    r_ovf      <= 1'b1;
                end else begin
                    r_scan_cnt <= r_scan_cnt + c_one;
                    r_ovf      <= 1'b0;
                end
                if (sync_clr) begin
                    r_rtc_cnt <= '0;
                end else if (w_scan_tc) begin
                    if (w_rtc_wrap) begin
                        r_rtc_cnt <= '0;
                        r_ovf_rtc <= 1'b1;
                    end else begin
                        r_rtc_cnt <= r_rtc_cnt + c_one;
                    end
                end
            end
        end
    end

    assign ovf       = r_ovf;
    assign ovf_RTC   = r_ovf_rtc;
    assign rtc_phase = r_rtc_cnt;
    assign running   = r_running;

    a_params_ok: assert property (@(posedge clk) disable iff (!reset) c_params_ok);

endmodule
`default_nettype wire

// File: tb/tb_tick_prescaler.sv
`default_nettype none
// Testbench for tick_prescaler: expected pulse events are queued per scenario
// and popped when the DUT reaches the matching cycle.
module tb_tick_prescaler;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic             fast;
    logic             sync_clr;
    logic             ovf;
    logic             ovf_RTC;
    logic             running;
    logic [CNT_W-1:0] rtc_phase;
    logic             ovf1;
    logic             rtc1;
    logic             run1;
    logic [CNT_W-1:0] ph1;
`ifdef RUNTIME_DIV_EN
    logic [CNT_W-1:0] div_scan;
    logic [CNT_W-1:0] div_rtc;
    logic             div_load;
`endif

    typedef struct {
        int               cyc;
        logic             rtc;
        logic [CNT_W-1:0] phase;
    } ev_t;

    ev_t sb[$];
    int  cyc      = 0;
    int  checks   = 0;
    int  failures = 0;

    tick_prescaler #(.SCAN_DIV(4), .RTC_DIV(3), .CNT_W(CNT_W)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .fast      (fast),
        .sync_clr  (sync_clr),
`ifdef RUNTIME_DIV_EN
        .div_scan  (div_scan),
        .div_rtc   (div_rtc),
        .div_load  (div_load),
`endif
        .ovf       (ovf),
        .ovf_RTC   (ovf_RTC),
        .rtc_phase (rtc_phase),
        .running   (running)
    );

    tick_prescaler #(.SCAN_DIV(1), .RTC_DIV(2), .CNT_W(CNT_W)) u_dut1 (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .fast      (fast),
        .sync_clr  (sync_clr),
`ifdef RUNTIME_DIV_EN
        .div_scan  (16'd0),
        .div_rtc   (16'd0),
        .div_load  (1'b0),
`endif
        .ovf       (ovf1),
        .ovf_RTC   (rtc1),
        .rtc_phase (ph1),
        .running   (run1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push(input int c, input logic r, input int p);
        ev_t e;
        e.cyc   = c;
        e.rtc   = r;
        e.phase = CNT_W'(p);
        sb.push_back(e);
    endfunction

    task automatic go_idle();
        @(negedge clk);
        en       = 1'b0;
        fast     = 1'b0;
        sync_clr = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        en       = 1'b0;
        fast     = 1'b0;
        sync_clr = 1'b0;
`ifdef RUNTIME_DIV_EN
        div_scan = '0;
        div_rtc  = '0;
        div_load = 1'b0;
`endif
        repeat (3) @(negedge clk);
        checks++;
        if ({ovf, ovf_RTC, rtc_phase, running} !== 19'd0) begin
            failures++;
            $display("FAIL reset_hold got ovf=%b rtc=%b phase=%0d run=%b want all 0", ovf, ovf_RTC, rtc_phase, running);
        end
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({ovf, ovf_RTC, rtc_phase, running} !== 19'd0) begin
                failures++;
                $display("FAIL reset_idle got ovf=%b rtc=%b phase=%0d run=%b want all 0", ovf, ovf_RTC, rtc_phase, running);
            end
        end
    endtask

    task automatic test_basic();
        int               c0;
        int               r;
        ev_t              e;
        logic [CNT_W-1:0] p1;
        @(negedge clk);
        c0 = cyc;
        en = 1'b1;
        for (int k = 1; k <= 8; k++) push(c0 + 2 + 4 * k, (k % 3) == 0, k % 3);
        r = -2;
        while (r < 33) begin
            @(negedge clk);
            r = cyc - c0 - 2;
            checks++;
            if (sb.size() != 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                if ({ovf, ovf_RTC, rtc_phase} !== {1'b1, e.rtc, e.phase}) begin
                    failures++;
                    $display("FAIL basic_pulse r=%0d got ovf=%b rtc=%b phase=%0d want ovf=1 rtc=%b phase=%0d", r, ovf, ovf_RTC, rtc_phase, e.rtc, e.phase);
                end
            end else if ({ovf, ovf_RTC} !== 2'b00) begin
                failures++;
                $display("FAIL basic_nopulse r=%0d got ovf=%b rtc=%b want 0 0", r, ovf, ovf_RTC);
            end
            checks++;
            if (running !== (r >= 0)) begin
                failures++;
                $display("FAIL basic_running r=%0d got %b want %b", r, running, (r >= 0));
            end
            p1 = (r >= 1) ? CNT_W'(r % 2) : '0;
            checks++;
            if ({ovf1, rtc1, ph1, run1} !== {(r >= 1), ((r >= 1) && ((r % 2) == 0)), p1, (r >= 0)}) begin
                failures++;
                $display("FAIL div1_outputs r=%0d got ovf=%b rtc=%b phase=%0d run=%b want ovf=%b rtc=%b phase=%0d run=%b",
                         r, ovf1, rtc1, ph1, run1, (r >= 1), ((r >= 1) && ((r % 2) == 0)), p1, (r >= 0));
            end
        end
    endtask

    task automatic test_fast();
        int  c0;
        int  r;
        ev_t e;
        go_idle();
        @(negedge clk);
        c0   = cyc;
        en   = 1'b1;
        fast = 1'b1;
        for (int k = 1; k <= 3; k++) push(c0 + 2 + 4 * k, 1'b1, 0);
        push(c0 + 2 + 16, 1'b0, 1);
        push(c0 + 2 + 20, 1'b0, 2);
        push(c0 + 2 + 24, 1'b1, 0);
        r = -2;
        while (r < 25) begin
            @(negedge clk);
            r = cyc - c0 - 2;
            checks++;
            if (sb.size() != 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                if ({ovf, ovf_RTC, rtc_phase} !== {1'b1, e.rtc, e.phase}) begin
                    failures++;
                    $display("FAIL fast_pulse r=%0d got ovf=%b rtc=%b phase=%0d want ovf=1 rtc=%b phase=%0d", r, ovf, ovf_RTC, rtc_phase, e.rtc, e.phase);
                end
            end else if ({ovf, ovf_RTC} !== 2'b00) begin
                failures++;
                $display("FAIL fast_nopulse r=%0d got ovf=%b rtc=%b want 0 0", r, ovf, ovf_RTC);
            end
            if (r == 13) fast = 1'b0;
        end
    endtask

    task automatic test_sync_clr();
        int  c0;
        int  r;
        ev_t e;
        go_idle();
        @(negedge clk);
        c0 = cyc;
        en = 1'b1;
        push(c0 + 2 + 4, 1'b0, 1);
        push(c0 + 2 + 8, 1'b0, 2);
        push(c0 + 2 + 12, 1'b0, 0);
        push(c0 + 2 + 16, 1'b0, 1);
        push(c0 + 2 + 20, 1'b0, 2);
        push(c0 + 2 + 24, 1'b1, 0);
        r = -2;
        while (r < 25) begin
            @(negedge clk);
            r = cyc - c0 - 2;
            checks++;
            if (sb.size() != 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                if ({ovf, ovf_RTC, rtc_phase} !== {1'b1, e.rtc, e.phase}) begin
                    failures++;
                    $display("FAIL sync_pulse r=%0d got ovf=%b rtc=%b phase=%0d want ovf=1 rtc=%b phase=%0d", r, ovf, ovf_RTC, rtc_phase, e.rtc, e.phase);
                end
            end else if ({ovf, ovf_RTC} !== 2'b00) begin
                failures++;
                $display("FAIL sync_nopulse r=%0d got ovf=%b rtc=%b want 0 0", r, ovf, ovf_RTC);
            end
            if (r == 11) sync_clr = 1'b1;
            if (r == 12) sync_clr = 1'b0;
        end
    endtask

    task automatic test_en_drop();
        int               c0;
        int               r;
        ev_t              e;
        logic [CNT_W-1:0] exp_ph;
        logic             exp_run;
        go_idle();
        @(negedge clk);
        c0 = cyc;
        en = 1'b1;
        push(c0 + 2 + 4, 1'b0, 1);
        r = -2;
        while (r < 10) begin
            @(negedge clk);
            r = cyc - c0 - 2;
            checks++;
            if (sb.size() != 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                if ({ovf, ovf_RTC, rtc_phase} !== {1'b1, e.rtc, e.phase}) begin
                    failures++;
                    $display("FAIL endrop_pulse r=%0d got ovf=%b rtc=%b phase=%0d want ovf=1 rtc=%b phase=%0d", r, ovf, ovf_RTC, rtc_phase, e.rtc, e.phase);
                end
            end else if ({ovf, ovf_RTC} !== 2'b00) begin
                failures++;
                $display("FAIL endrop_nopulse r=%0d got ovf=%b rtc=%b want 0 0", r, ovf, ovf_RTC);
            end
            exp_run = (r >= 0) && (r <= 6);
            exp_ph  = ((r >= 4) && (r <= 6)) ? CNT_W'(1) : '0;
            checks++;
            if ({running, rtc_phase} !== {exp_run, exp_ph}) begin
                failures++;
                $display("FAIL endrop_state r=%0d got run=%b phase=%0d want run=%b phase=%0d", r, running, rtc_phase, exp_run, exp_ph);
            end
            if (r == 6) en = 1'b0;
        end
        c0 = cyc;
        en = 1'b1;
        push(c0 + 2 + 4, 1'b0, 1);
        r = -2;
        while (r < 5) begin
            @(negedge clk);
            r = cyc - c0 - 2;
            checks++;
            if (sb.size() != 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                if ({ovf, ovf_RTC, rtc_phase} !== {1'b1, e.rtc, e.phase}) begin
                    failures++;
                    $display("FAIL reen_pulse r=%0d got ovf=%b rtc=%b phase=%0d want ovf=1 rtc=%b phase=%0d", r, ovf, ovf_RTC, rtc_phase, e.rtc, e.phase);
                end
            end else if ({ovf, ovf_RTC} !== 2'b00) begin
                failures++;
                $display("FAIL reen_nopulse r=%0d got ovf=%b rtc=%b want 0 0", r, ovf, ovf_RTC);
            end
            checks++;
            if (running !== (r >= 0)) begin
                failures++;
                $display("FAIL reen_running r=%0d got %b want %b", r, running, (r >= 0));
            end
        end
    endtask

    task automatic test_reset_mid();
        int  c0;
        int  r;
        ev_t e;
        go_idle();
        @(negedge clk);
        c0 = cyc;
        en = 1'b1;
        push(c0 + 2 + 4, 1'b0, 1);
        r = -2;
        while (r < 6) begin
            @(negedge clk);
            r = cyc - c0 - 2;
            checks++;
            if (sb.size() != 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                if ({ovf, ovf_RTC, rtc_phase} !== {1'b1, e.rtc, e.phase}) begin
                    failures++;
                    $display("FAIL rmid_pulse r=%0d got ovf=%b rtc=%b phase=%0d want ovf=1 rtc=%b phase=%0d", r, ovf, ovf_RTC, rtc_phase, e.rtc, e.phase);
                end
            end else if ({ovf, ovf_RTC} !== 2'b00) begin
                failures++;
                $display("FAIL rmid_nopulse r=%0d got ovf=%b rtc=%b want 0 0", r, ovf, ovf_RTC);
            end
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({ovf, ovf_RTC, rtc_phase, running} !== 19'd0) begin
            failures++;
            $display("FAIL rmid_async got ovf=%b rtc=%b phase=%0d run=%b want all 0", ovf, ovf_RTC, rtc_phase, running);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        c0 = cyc;
        push(c0 + 2 + 4, 1'b0, 1);
        r = -2;
        while (r < 5) begin
            @(negedge clk);
            r = cyc - c0 - 2;
            checks++;
            if (sb.size() != 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                if ({ovf, ovf_RTC, rtc_phase} !== {1'b1, e.rtc, e.phase}) begin
                    failures++;
                    $display("FAIL rrel_pulse r=%0d got ovf=%b rtc=%b phase=%0d want ovf=1 rtc=%b phase=%0d", r, ovf, ovf_RTC, rtc_phase, e.rtc, e.phase);
                end
            end else if ({ovf, ovf_RTC} !== 2'b00) begin
                failures++;
                $display("FAIL rrel_nopulse r=%0d got ovf=%b rtc=%b want 0 0", r, ovf, ovf_RTC);
            end
            checks++;
            if (running !== (r >= 0)) begin
                failures++;
                $display("FAIL rrel_running r=%0d got %b want %b", r, running, (r >= 0));
            end
        end
    endtask

`ifdef RUNTIME_DIV_EN
    task automatic test_runtime_div();
        int  c0;
        int  r;
        ev_t e;
        go_idle();
        @(negedge clk);
        c0 = cyc;
        en = 1'b1;
        push(c0 + 2 + 4, 1'b0, 1);
        for (int k = 0; k < 4; k++) push(c0 + 2 + 10 + 2 * k, 1'b1, 0);
        r = -2;
        while (r < 17) begin
            @(negedge clk);
            r = cyc - c0 - 2;
            checks++;
            if (sb.size() != 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                if ({ovf, ovf_RTC, rtc_phase} !== {1'b1, e.rtc, e.phase}) begin
                    failures++;
                    $display("FAIL rtdiv_pulse r=%0d got ovf=%b rtc=%b phase=%0d want ovf=1 rtc=%b phase=%0d", r, ovf, ovf_RTC, rtc_phase, e.rtc, e.phase);
                end
            end else if ({ovf, ovf_RTC} !== 2'b00) begin
                failures++;
                $display("FAIL rtdiv_nopulse r=%0d got ovf=%b rtc=%b want 0 0", r, ovf, ovf_RTC);
            end
            if (r == 7) begin
                div_scan = 16'd2;
                div_rtc  = 16'd0;
                div_load = 1'b1;
            end
            if (r == 8) div_load = 1'b0;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_fast();
        test_sync_clr();
        test_en_drop();
        test_reset_mid();
`ifdef RUNTIME_DIV_EN
        test_runtime_div();
`endif
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover got %0d pending events want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
